// File: rtl/hs_fifo_sfifo_wr_arb.sv
// hs_fifo_sfifo_wr_arb
// Packet-aware round-robin arbiter sharing the single sfifo write port
// between NUM_REQ requesters. A requester owns the port from its first beat
// until the beat carrying wlast or wdrop is accepted, so packets from
// different requesters never interleave inside the FIFO.
//
// Optional feature (compile-time macro HS_FIFO_SFIFO_WR_ARB_AFULL_GATE_EN):
//   defined   - no new grant is issued in IDLE while m_walmost_full is high;
//               a packet already locked completes normally.
//   undefined - m_walmost_full is ignored.
module hs_fifo_sfifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    localparam int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic [NUM_REQ-1:0]            s_wvalid,
    output logic [NUM_REQ-1:0]            s_wready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_wdata,
    input  logic [NUM_REQ-1:0]            s_wlast,
    input  logic [NUM_REQ-1:0]            s_wdrop,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    output logic [DATA_WIDTH-1:0]         m_wdata,
    output logic                          m_wlast,
    output logic                          m_wdrop,
    input  logic                          m_walmost_full,
    output logic                          grant_vld,
    output logic [IDX_WIDTH-1:0]          grant_idx
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t               state;
    logic [IDX_WIDTH-1:0] rr_ptr;

    logic                 any_req;
    logic                 grant_ok;
    logic [IDX_WIDTH-1:0] pick_idx;
    logic [IDX_WIDTH-1:0] next_ptr;
    logic                 acc;
    logic                 pkt_end;

    logic [DATA_WIDTH-1:0] req_data [NUM_REQ];

    // Round-robin search: first set request starting at ptr, wrapping.
    // The request vector is rotated so that position 0 corresponds to ptr;
    // scanning from the top down leaves the lowest rotated position in idx.
    function automatic logic [IDX_WIDTH-1:0] rr_pick(
        input logic [NUM_REQ-1:0]   vld,
        input logic [IDX_WIDTH-1:0] ptr
    );
        logic [2*NUM_REQ-1:0]  rot;
        logic [IDX_WIDTH-1:0]  idx;
        int                    j;
        rot = {vld, vld} >> ptr;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                j = int'(ptr) + k;
                if (j >= NUM_REQ) begin
                    j = j - NUM_REQ;
                end
                idx = IDX_WIDTH'(j);
            end
        end
        return idx;
    endfunction

    // Pointer that follows the current owner, wrapping after the last index.
    function automatic logic [IDX_WIDTH-1:0] wrap_inc(
        input logic [IDX_WIDTH-1:0] g
    );
        logic [IDX_WIDTH-1:0] r;
        if (g == IDX_WIDTH'(NUM_REQ - 1)) begin
            r = '0;
        end else begin
            r = g + 1'b1;
        end
        return r;
    endfunction

    // Unpack the flat requester data bus into one word per requester.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i] = s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign any_req  = |s_wvalid;
    assign pick_idx = rr_pick(s_wvalid, rr_ptr);
    assign next_ptr = wrap_inc(grant_idx);

`ifdef HS_FIFO_SFIFO_WR_ARB_AFULL_GATE_EN
    // Hold off new packets while the FIFO is nearly full; an owner in LOCK
    // is never affected by this gate.
    assign grant_ok = any_req & ~m_walmost_full;
`else
    logic afull_unused;
    assign afull_unused = m_walmost_full;
    assign grant_ok     = any_req;
`endif

    // Combinational datapath: the locked requester is steered straight to
    // the FIFO, nothing registered on data so the sfifo hold rule carries
    // through unchanged from requester to FIFO.
    always_comb begin
        m_wvalid = 1'b0;
        m_wdata  = req_data[grant_idx];
        m_wlast  = s_wlast[grant_idx];
        m_wdrop  = s_wdrop[grant_idx];
        s_wready = '0;
        if (state == LOCK) begin
            m_wvalid            = s_wvalid[grant_idx];
            s_wready[grant_idx] = m_wready;
        end
    end

    // A drop beat closes the packet exactly like a last beat.
    assign acc     = m_wvalid & m_wready;
    assign pkt_end = acc & (m_wlast | m_wdrop);

    // Grant FSM: IDLE picks the next owner by rr_ptr, LOCK holds it until the
    // packet-ending beat is accepted, then the pointer moves past the owner.
    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            grant_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        grant_idx <= pick_idx;
                        grant_vld <= 1'b1;
                        state     <= LOCK;
                    end
                end
                LOCK: begin
                    if (pkt_end) begin
                        grant_vld <= 1'b0;
                        rr_ptr    <= next_ptr;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    grant_vld <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // At most one requester sees its beat accepted in any cycle.
    always_ff @(posedge clk) begin
        if (!srst) begin
            assert ($onehot0(s_wready))
                else $error("s_wready not onehot0: %b", s_wready);
        end
    end

    // The owner never changes inside a packet.
    property p_grant_stable;
        @(posedge clk) disable iff (srst)
            (grant_vld && !pkt_end) |=> (grant_idx == $past(grant_idx));
    endproperty
    a_grant_stable: assert property (p_grant_stable)
        else $error("grant_idx changed inside a packet");
`endif

endmodule
